// File: rtl/alu_pkg.sv
// Shared types for the handshaked sequential ALU: opcodes, FSM states and the flag bundle.

package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'd0,
      OP_OR  = 4'd1,
      OP_ADD = 4'd2,
      OP_GTU = 4'd3,
      OP_SUB = 4'd4,
      OP_XOR = 4'd5,
      OP_NOR = 4'd6,
      OP_SLT = 4'd7,
      OP_SLL = 4'd8,
      OP_SRL = 4'd9,
      OP_SRA = 4'd10,
      OP_MUL = 4'd11
   } op_e;

   localparam logic [3:0] OP_ILLEGAL_MIN = 4'd12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic zero;
      logic carry;
      logic ovf;
      logic neg;
      logic illegal;
   } flags_t;

   localparam flags_t FLAGS_RESET = '{zero: 1'b1, default: 1'b0};

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-read stage and the sequential ALU.

interface alu_seq_if #(
   parameter int unsigned WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [3:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] r;
   logic             isZero;
   logic             carry;
   logic             ovf;
   logic             neg;
   logic             illegal;

   modport master (
      output in_valid, in_a, in_b, op, out_ready,
      input  in_ready, out_valid, r, isZero, carry, ovf, neg, illegal
   );

   modport slave (
      input  in_valid, in_a, in_b, op, out_ready,
      output in_ready, out_valid, r, isZero, carry, ovf, neg, illegal
   );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.

module alu_mul_iter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_sum;

   // product is the accumulator after the current step, so the final step can be captured directly
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign busy    = (cnt_q != '0);
   assign done    = (cnt_q == CW'(1));
   assign product = acc_sum;

   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (start) begin
         cnt_d    = CW'(WIDTH);
         acc_d    = '0;
         mcand_d  = a;
         mplier_d = b;
      end else if (busy) begin
         cnt_d    = cnt_q - CW'(1);
         acc_d    = acc_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Stallable execute unit: valid/ready front end, single-cycle op mux, iterative MUL,
// registered result and flags.

module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic     clk,
   input  logic     reset,
   alu_seq_if.slave bus
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned MSB = WIDTH - 1;

   state_e           state_q, state_d;
   logic             in_ready;
   logic             accept;
   logic             is_mul;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic             load_alu;
   logic             load_mul;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] alu_r;
   flags_t           alu_f;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [SHW-1:0]   amt;
   logic [WIDTH-1:0] r_q, r_d;
   flags_t           flags_q, flags_d;
   logic             out_valid_q, out_valid_d;

   alu_mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk    (clk),
      .reset  (reset),
      .start  (mul_start),
      .a      (bus.in_a),
      .b      (bus.in_b),
      .busy   (mul_busy),
      .done   (mul_done),
      .product(mul_product)
   );

   assign sum    = {1'b0, bus.in_a} + {1'b0, bus.in_b};
   assign diff   = {1'b0, bus.in_a} - {1'b0, bus.in_b};
   assign amt    = bus.in_b[SHW-1:0];
   assign is_mul = (bus.op == OP_MUL);

   always_comb begin
      alu_r         = '0;
      alu_f         = '0;
      alu_f.illegal = 1'b0;
      case (bus.op)
         OP_AND: alu_r = bus.in_a & bus.in_b;
         OP_OR:  alu_r = bus.in_a | bus.in_b;
         OP_ADD: begin
            alu_r       = sum[WIDTH-1:0];
            alu_f.carry = sum[WIDTH];
            alu_f.ovf   = (bus.in_a[MSB] == bus.in_b[MSB]) && (alu_r[MSB] != bus.in_a[MSB]);
         end
         OP_GTU: alu_r = {{(WIDTH-1){1'b0}}, bus.in_a > bus.in_b};
         OP_SUB: begin
            // carry doubles as borrow: set when a < b unsigned
            alu_r       = diff[WIDTH-1:0];
            alu_f.carry = diff[WIDTH];
            alu_f.ovf   = (bus.in_a[MSB] != bus.in_b[MSB]) && (alu_r[MSB] != bus.in_a[MSB]);
         end
         OP_XOR: alu_r = bus.in_a ^ bus.in_b;
         OP_NOR: alu_r = ~(bus.in_a | bus.in_b);
         OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
         OP_SLL: alu_r = bus.in_a << amt;
         OP_SRL: alu_r = bus.in_a >> amt;
         OP_SRA: alu_r = $unsigned($signed(bus.in_a) >>> amt);
         OP_MUL: alu_r = '0;
         default: alu_f.illegal = 1'b1;
      endcase
      alu_f.zero = (alu_r == '0);
      alu_f.neg  = alu_r[MSB];
   end

   // in_ready looks only at state and out_ready so the producer never sees a combinational loop
   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      mul_start = 1'b0;
      load_alu  = 1'b0;
      load_mul  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               if (is_mul) begin
                  mul_start = 1'b1;
                  state_d   = BUSY;
               end else begin
                  load_alu = 1'b1;
                  state_d  = DONE;
               end
            end else if ((state_q == DONE) && bus.out_ready) begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (mul_done) begin
               load_mul = 1'b1;
               state_d  = DONE;
            end else if (!mul_busy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      r_d         = r_q;
      flags_d     = flags_q;
      out_valid_d = (state_d == DONE);
      if (load_alu) begin
         r_d     = alu_r;
         flags_d = alu_f;
      end else if (load_mul) begin
         r_d           = mul_product;
         flags_d       = '0;
         flags_d.zero  = (mul_product == '0);
         flags_d.neg   = mul_product[MSB];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         r_q         <= '0;
         flags_q     <= FLAGS_RESET;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.r         = r_q;
   assign bus.isZero    = flags_q.zero;
   assign bus.carry     = flags_q.carry;
   assign bus.ovf       = flags_q.ovf;
   assign bus.neg       = flags_q.neg;
   assign bus.illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: integer-arithmetic reference model, scoreboard queue,
// literal expectations from hand calculation, latency/backpressure/reset scenarios.

module tb_alu_seq;

   localparam int          W    = 16;
   localparam int unsigned MOD  = 65536;
   localparam int unsigned HALF = 32768;

   typedef struct {
      int unsigned a;
      int unsigned b;
      int          op;
      int unsigned lr;
      bit [4:0]    lf;   // {zero, carry, ovf, neg, illegal}
   } vec_t;

   typedef struct {
      int          idx;
      int unsigned r;
      bit [4:0]    f;
      int unsigned lr;
      bit [4:0]    lf;
   } exp_t;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_miss;
   vec_t vecs[18];
   exp_t exp_q[$];
   exp_t cur;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(
      .WIDTH(W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic on the opcode definitions.
   function automatic exp_t model(input int unsigned a, input int unsigned b, input int op);
      exp_t        e;
      int          sa, sb, s;
      int unsigned r, amt;
      longint unsigned p;
      bit          c, v, ill;
      sa  = (a >= HALF) ? int'(a) - int'(MOD) : int'(a);
      sb  = (b >= HALF) ? int'(b) - int'(MOD) : int'(b);
      amt = b % W;
      r = 0; c = 0; v = 0; ill = 0;
      case (op)
         0: r = a & b;
         1: r = a | b;
         2: begin
            r = (a + b) % MOD;
            c = (a + b) >= MOD;
            s = sa + sb;
            v = (s > 32767) || (s < -32768);
         end
         3: r = (a > b) ? 1 : 0;
         4: begin
            r = (a + MOD - b) % MOD;
            c = a < b;
            s = sa - sb;
            v = (s > 32767) || (s < -32768);
         end
         5: r = a ^ b;
         6: r = (MOD - 1) - (a | b);
         7: r = (sa < sb) ? 1 : 0;
         8: r = (a << amt) % MOD;
         9: r = a >> amt;
         10: r = int'(unsigned'(sa >>> amt)) % MOD;
         11: begin
            p = longint'(a) * longint'(b);
            r = int'(p % MOD);
         end
         default: ill = 1;
      endcase
      e.r  = r;
      e.f  = {r == 0, c, v, r >= HALF, ill};
      e.idx = 0;
      e.lr = 0;
      e.lf = 0;
      return e;
   endfunction

   // Every cycle a result is presented, it must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!reset && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL spurious_out_valid: got out_valid=1, required 0 (nothing pending)");
         end else begin
            cur = exp_q[0];
            check($sformatf("v%0d_r_model", cur.idx), 32'(bus.r), cur.r);
            check($sformatf("v%0d_flags_model", cur.idx),
                  {27'd0, bus.isZero, bus.carry, bus.ovf, bus.neg, bus.illegal}, {27'd0, cur.f});
            check($sformatf("v%0d_r_literal", cur.idx), 32'(bus.r), cur.lr);
            check($sformatf("v%0d_flags_literal", cur.idx),
                  {27'd0, bus.isZero, bus.carry, bus.ovf, bus.neg, bus.illegal}, {27'd0, cur.lf});
            check($sformatf("v%0d_in_ready_eq_out_ready", cur.idx),
                  32'(bus.in_ready), 32'(bus.out_ready));
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic issue(input int idx, output int waits);
      exp_t e;
      logic rdy;
      bus.in_a     = 16'(vecs[idx].a);
      bus.in_b     = 16'(vecs[idx].b);
      bus.op       = 4'(vecs[idx].op);
      bus.in_valid = 1'b1;
      waits = 0;
      do begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         waits++;
      end while (!rdy && waits < 64);
      if (!rdy) begin
         check($sformatf("v%0d_accept_timeout", idx), 32'(waits), 32'd0);
      end else begin
         e     = model(vecs[idx].a, vecs[idx].b, vecs[idx].op);
         e.idx = idx;
         e.lr  = vecs[idx].lr;
         e.lf  = vecs[idx].lf;
         exp_q.push_back(e);
      end
      #1;
   endtask

   task automatic wait_valid(input int idx, input int exp_lat, output int busy_cycles);
      int lat;
      lat = 0;
      busy_cycles = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!bus.in_ready) busy_cycles++;
      end while (!bus.out_valid && lat < 64);
      check($sformatf("v%0d_latency", idx), 32'(lat), 32'(exp_lat));
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      check({pfx, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({pfx, "_r"}, 32'(bus.r), 32'd0);
      check({pfx, "_flags"}, {27'd0, bus.isZero, bus.carry, bus.ovf, bus.neg, bus.illegal},
            32'b10000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w, bc, cnt;
      n_vec  = 0;
      n_miss = 0;
      vecs = '{
         '{32'h00F0, 32'h0F0F, 0,  32'h0000, 5'b10000},  // AND
         '{32'h00F0, 32'h0F0F, 1,  32'h0FFF, 5'b00000},  // OR
         '{32'h00F0, 32'h0F0F, 2,  32'h0FFF, 5'b00000},  // ADD
         '{32'h00F0, 32'h0F0F, 3,  32'h0000, 5'b10000},  // GTU false
         '{32'h00F0, 32'h0F0F, 4,  32'hF1E1, 5'b01010},  // SUB borrow
         '{32'h7FFF, 32'h0001, 2,  32'h8000, 5'b00110},  // ADD signed overflow
         '{32'hFFFF, 32'h0001, 2,  32'h0000, 5'b11000},  // ADD carry out
         '{32'h8000, 32'h000F, 10, 32'hFFFF, 5'b00010},  // SRA
         '{32'h8000, 32'h000F, 9,  32'h0001, 5'b00000},  // SRL
         '{32'hFFFF, 32'h0001, 7,  32'h0001, 5'b00000},  // SLT
         '{32'h00F0, 32'h0F0F, 5,  32'h0FFF, 5'b00000},  // XOR
         '{32'h00F0, 32'h0F0F, 6,  32'hF000, 5'b00010},  // NOR
         '{32'h0001, 32'h0004, 8,  32'h0010, 5'b00000},  // SLL
         '{32'h1234, 32'h5678, 13, 32'h0000, 5'b10001},  // illegal
         '{32'h0123, 32'h0045, 11, 32'h4E6F, 5'b00000},  // MUL
         '{32'hFFFF, 32'hFFFF, 11, 32'h0001, 5'b00000},  // MUL wrap
         '{32'h8000, 32'h0001, 4,  32'h7FFF, 5'b00100},  // SUB signed overflow
         '{32'h0F0F, 32'h00F0, 3,  32'h0001, 5'b00000}   // GTU true
      };
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.op        = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk);
      #1;

      for (int i = 0; i < 18; i++) begin
         issue(i, w);
         bus.in_valid = 1'b0;
         wait_valid(i, (vecs[i].op == 11) ? W + 1 : 1, bc);
         if (vecs[i].op == 11) check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(W));
         @(posedge clk);
         #1;
      end

      // Backpressure: hold a SUB result, then release with a new request in the same edge.
      bus.out_ready = 1'b0;
      issue(4, w);
      bus.in_valid = 1'b0;
      wait_valid(4, 1, bc);
      repeat (5) @(posedge clk);
      #1;
      check("bp_in_ready_held", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      issue(5, w);
      check("bp_accept_waits", 32'(w), 32'd1);
      bus.in_valid = 1'b0;
      wait_valid(5, 1, bc);
      @(posedge clk);
      #1;

      // Back-to-back single-cycle ops with out_ready held high.
      issue(10, w);
      issue(11, w);
      check("burst_accept_waits_1", 32'(w), 32'd1);
      issue(12, w);
      check("burst_accept_waits_2", 32'(w), 32'd1);
      bus.in_valid = 1'b0;
      wait_valid(12, 1, bc);
      @(posedge clk);
      #1;

      // Reset in the fifth cycle of a MUL: the operation is abandoned.
      issue(14, w);
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_values("rst_mul");
      cnt = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus.out_valid) cnt++;
      end
      check("rst_mul_no_out_valid", 32'(cnt), 32'd0);
      @(posedge clk);
      #1;

      issue(13, w);
      bus.in_valid = 1'b0;
      wait_valid(13, 1, bc);
      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
